// File: rtl/rs_chien_search.sv
// rs_chien_search: sequential Chien search over GF(2^8) (poly 0x11D, alpha=0x02)
// for a degree<=3 error-locator polynomial sigma(x) = s0 + s1 x + s2 x^2 + s3 x^3.
// A start strobe captures sigma; one locator position is tested per cycle and
// the results are held until the next capture.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   signal           start strobe, s0..s3 valid with it; ignored while busy
//   s0..s3           sigma coefficients, x^0..x^3
//   busy             search in progress
//   ready            one-cycle pulse, results valid from this cycle
//   err_pos[N-1:0]   bit j set = root at alpha^-j (locator alpha^j)
//   err_cnt[2:0]     number of roots found (saturates at 7)
//   fail             s0==0 or root count differs from the degree of sigma
//
// Optional feature: define RS_CHIEN_EARLY_STOP_EN to end the search as soon as
// the root count reaches deg(sigma).
module rs_chien_search #(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         signal,
    input  logic [7:0]   s0,
    input  logic [7:0]   s1,
    input  logic [7:0]   s2,
    input  logic [7:0]   s3,
    output logic         busy,
    output logic         ready,
    output logic [N-1:0] err_pos,
    output logic [2:0]   err_cnt,
    output logic         fail
);

    localparam int unsigned SW = 8;
    localparam int unsigned JW = 8;
    localparam int unsigned CW = 3;

`ifdef RS_CHIEN_EARLY_STOP_EN
    localparam bit EarlyStop = 1'b1;
`else
    localparam bit EarlyStop = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Multiply by alpha^-1: shift right, fold the dropped bit back as 0x11D>>1.
    function automatic logic [SW-1:0] mul_ainv(input logic [SW-1:0] x);
        mul_ainv = {1'b0, x[SW-1:1]} ^ (x[0] ? 8'h8E : 8'h00);
    endfunction

    state_e          state_q, state_d;
    logic [SW-1:0]   t0_q, t1_q, t2_q, t3_q;
    logic [SW-1:0]   t0_d, t1_d, t2_d, t3_d;
    logic [JW-1:0]   j_q, j_d;
    logic [1:0]      deg_q, deg_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [N-1:0]    err_pos_q, err_pos_d;
    logic [CW-1:0]   err_cnt_q, err_cnt_d;
    logic            fail_q, fail_d;

    logic [1:0]      deg_in_c;
    logic            root_c;
    logic [CW-1:0]   cnt_step_c;
    logic            last_step_c;

    // Degree of the incoming sigma (0 when only s0 or nothing is nonzero).
    always_comb begin
        deg_in_c = 2'd0;
        if (s3 != 8'h00)      deg_in_c = 2'd3;
        else if (s2 != 8'h00) deg_in_c = 2'd2;
        else if (s1 != 8'h00) deg_in_c = 2'd1;
    end

    // Current term sum is sigma(alpha^-j); count after this step.
    always_comb begin
        root_c      = ((t0_q ^ t1_q ^ t2_q ^ t3_q) == 8'h00);
        cnt_step_c  = err_cnt_q;
        if (root_c && (err_cnt_q != 3'd7)) cnt_step_c = err_cnt_q + 3'd1;
        last_step_c = (j_q == JW'(N - 1))
                   || (EarlyStop && root_c && (cnt_step_c == {1'b0, deg_q}));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (signal) begin
                    state_d = (EarlyStop && (deg_in_c == 2'd0)) ? ST_DONE : ST_SEARCH;
                end
            end
            ST_SEARCH: if (last_step_c) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath / registered-output next values
    always_comb begin
        t0_d      = t0_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        t3_d      = t3_q;
        j_d       = j_q;
        deg_d     = deg_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        err_pos_d = err_pos_q;
        err_cnt_d = err_cnt_q;
        fail_d    = fail_q;
        case (state_q)
            ST_IDLE: begin
                if (signal) begin
                    t0_d      = s0;
                    t1_d      = s1;
                    t2_d      = s2;
                    t3_d      = s3;
                    j_d       = '0;
                    deg_d     = deg_in_c;
                    busy_d    = 1'b1;
                    err_pos_d = '0;
                    err_cnt_d = '0;
                    fail_d    = 1'b0;
                end
            end
            ST_SEARCH: begin
                if (root_c) err_pos_d = err_pos_q | (N'(1) << j_q);
                err_cnt_d = cnt_step_c;
                t1_d      = mul_ainv(t1_q);
                t2_d      = mul_ainv(mul_ainv(t2_q));
                t3_d      = mul_ainv(mul_ainv(mul_ainv(t3_q)));
                j_d       = j_q + JW'(1);
            end
            ST_DONE: begin
                // t0 never changes, so it still equals the captured s0.
                ready_d = 1'b1;
                busy_d  = 1'b0;
                fail_d  = (t0_q == 8'h00) || (err_cnt_q != {1'b0, deg_q});
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t0_q      <= '0;
            t1_q      <= '0;
            t2_q      <= '0;
            t3_q      <= '0;
            j_q       <= '0;
            deg_q     <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            err_pos_q <= '0;
            err_cnt_q <= '0;
            fail_q    <= 1'b0;
        end else begin
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            t3_q      <= t3_d;
            j_q       <= j_d;
            deg_q     <= deg_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            err_pos_q <= err_pos_d;
            err_cnt_q <= err_cnt_d;
            fail_q    <= fail_d;
        end
    end

    assign busy    = busy_q;
    assign ready   = ready_q;
    assign err_pos = err_pos_q;
    assign err_cnt = err_cnt_q;
    assign fail    = fail_q;

endmodule
